// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: W-bit add/subtract built from one 4-bit adder slice,
// reused once per nibble (LSB first) under a valid/ready handshake.
module serial_adder_ctrl #(
    parameter int NIB = 4
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [4*NIB-1:0]  i_a,
    input  logic [4*NIB-1:0]  i_b,
    input  logic              i_c,
    input  logic              i_sub,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [4*NIB-1:0]  o_s,
    output logic              o_c,
    output logic              o_ovf
);
    localparam int W = 4*NIB;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state, state_next;
    logic [W-1:0]   a_q, b_q, work_q, work_next, s_q;
    logic [2:0]     cnt;
    logic           carry_q, c_q, ovf_q;
    logic [3:0]     nib_a, nib_b, lo, sum;
    logic [1:0]     hi;
    logic           last, accept;

    assign accept = (state == IDLE) && i_valid;
    assign last   = (cnt == 3'(NIB-1));

    // The single slice: low three bits first so the carry into bit 3 is visible for overflow.
    always_comb begin
        nib_a = a_q[4*cnt +: 4];
        nib_b = b_q[4*cnt +: 4];
        lo    = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b0, carry_q};
        hi    = {1'b0, nib_a[3]} + {1'b0, nib_b[3]} + {1'b0, lo[3]};
        sum   = {hi[0], lo[2:0]};
        work_next = work_q;
        work_next[4*cnt +: 4] = sum;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = i_valid ? CALC : IDLE;
            CALC:    state_next = last ? DONE : CALC;
            DONE:    state_next = i_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE);
        o_valid = (state == DONE);
    end

    // Working sum is kept apart from s_q so the visible result holds until the next one completes.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            s_q     <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= i_a;
            b_q     <= i_sub ? ~i_b : i_b;
            carry_q <= i_sub | i_c;
            cnt     <= '0;
        end else if (state == CALC) begin
            work_q  <= work_next;
            carry_q <= hi[1];
            cnt     <= last ? 3'd0 : cnt + 3'd1;
            if (last) begin
                s_q   <= work_next;
                c_q   <= hi[1];
                ovf_q <= hi[1] ^ lo[3];
            end
        end
    end

    assign o_s   = s_q;
    assign o_c   = c_q;
    assign o_ovf = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and randomized checks of serial_adder_ctrl
// against an integer-arithmetic reference model.
module tb_serial_adder_ctrl;
    localparam int NIB = 4;
    localparam int W   = 4*NIB;

    logic         clk = 1'b0;
    logic         rstn, in_valid, out_ready, in_c, in_sub, out_valid, in_ready, out_c, out_ovf;
    logic [W-1:0] in_a, in_b, out_s;
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.NIB(NIB)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_valid(in_valid), .o_ready(out_ready),
        .i_a(in_a), .i_b(in_b), .i_c(in_c), .i_sub(in_sub),
        .o_valid(out_valid), .i_ready(in_ready),
        .o_s(out_s), .o_c(out_c), .o_ovf(out_ovf)
    );

    // Reference: plain integer arithmetic on the full operand values.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                  input logic sub, output logic [W-1:0] s, output logic co,
                                  output logic ov);
        longint ua, ub, sa, sb, r, ur;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[W-1] ? ua - (64'sd1 <<< W) : ua;
        sb = b[W-1] ? ub - (64'sd1 <<< W) : ub;
        if (sub) begin
            ur = ua - ub;
            co = (ua >= ub);
            r  = sa - sb;
        end else begin
            ur = ua + ub + longint'(c);
            co = (ur >= (64'sd1 <<< W));
            r  = sa + sb + longint'(c);
        end
        s  = W'(ur);
        ov = (r > (64'sd1 <<< (W-1)) - 1) || (r < -(64'sd1 <<< (W-1)));
    endfunction

    // Issues one request and waits for the result; edges counts the accepting edge too.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic sub, output int edges);
        @(negedge clk);
        in_a = a; in_b = b; in_c = c; in_sub = sub; in_valid = 1'b1; in_ready = 1'b0;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        in_a = W'($urandom); in_b = W'($urandom); in_c = 1'($urandom); in_sub = 1'($urandom);
        while (!out_valid && edges < 40) begin
            in_ready = 1'($urandom);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        in_ready = 1'b0;
    endtask

    task automatic release_result();
        @(negedge clk);
        in_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
        in_a = '0; in_b = '0; in_c = 1'b0; in_sub = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || out_s !== '0 || out_c !== 1'b0 || out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%b s=%h c=%b ovf=%b, want 0/0/0/0",
                     out_valid, out_s, out_c, out_ovf);
        end
        rstn = 1'b1;
        @(negedge clk);
        tests++;
        if (out_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: o_ready=%b, want 1", out_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va[5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [W-1:0] vb[5] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
        logic         vsub[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] es[5] = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
        logic         ec[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic         eo[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int edges;
        for (int i = 0; i < 5; i++) begin
            issue(va[i], vb[i], 1'b0, vsub[i], edges);
            tests++;
            if (edges !== NIB+1 || out_s !== es[i] || out_c !== ec[i] || out_ovf !== eo[i]) begin
                fails++;
                $display("FAIL directed_%0d: edges=%0d s=%h c=%b ovf=%b, want %0d %h %b %b",
                         i, edges, out_s, out_c, out_ovf, NIB+1, es[i], ec[i], eo[i]);
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int edges;
        issue(16'h1234, 16'h4321, 1'b1, 1'b0, edges);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_a = W'($urandom); in_valid = ~in_valid;
            tests++;
            if (out_valid !== 1'b1 || out_ready !== 1'b0 || out_s !== 16'h5556) begin
                fails++;
                $display("FAIL backpressure_%0d: valid=%b ready=%b s=%h, want 1 0 5556",
                         i, out_valid, out_ready, out_s);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; in_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_ready = 1'b0;
        tests++;
        if (out_ready !== 1'b1 || out_valid !== 1'b0 || out_s !== 16'h5556) begin
            fails++;
            $display("FAIL backpressure_release: ready=%b valid=%b s=%h, want 1 0 5556",
                     out_ready, out_valid, out_s);
        end
    endtask

    task automatic test_reset_mid_calc();
        int edges;
        @(negedge clk);
        in_a = 16'hABCD; in_b = 16'h1111; in_c = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_s !== '0 || out_c !== 1'b0 || out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_calc: valid=%b s=%h c=%b ovf=%b, want 0 0 0 0",
                     out_valid, out_s, out_c, out_ovf);
        end
        @(negedge clk);
        rstn = 1'b1;
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, edges);
        tests++;
        if (edges !== NIB+1 || out_s !== 16'h0002 || out_c !== 1'b0 || out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_op: edges=%0d s=%h c=%b ovf=%b, want %0d 0002 0 0",
                     edges, out_s, out_c, out_ovf, NIB+1);
        end
        release_result();
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, es;
        logic         c, sub, ec, eo;
        int           edges;
        for (int n = 0; n < 2000; n++) begin
            a = W'($urandom); b = W'($urandom); c = 1'($urandom); sub = 1'($urandom);
            if (n % 8 == 0) a = {1'b0, {(W-1){1'b1}}};
            if (n % 8 == 1) b = '1;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            model(a, b, c, sub, es, ec, eo);
            tests++;
            if (out_ready !== 1'b1 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL rand_idle_%0d: ready=%b valid=%b, want 1 0", n, out_ready, out_valid);
            end
            issue(a, b, c, sub, edges);
            tests++;
            if (edges !== NIB+1 || out_s !== es || out_c !== ec || out_ovf !== eo) begin
                fails++;
                $display("FAIL rand_%0d a=%h b=%h c=%b sub=%b: edges=%0d s=%h c=%b ovf=%b, want %0d %h %b %b",
                         n, a, b, c, sub, edges, out_s, out_c, out_ovf, NIB+1, es, ec, eo);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || out_s !== es) begin
                fails++;
                $display("FAIL rand_hold_%0d: valid=%b s=%h, want 1 %h", n, out_valid, out_s, es);
            end
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_calc();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: NIB, default 4, number of 4-bit slices per operand; operand width W = 4*NIB; legal range 1..8.
REQ-002 Port: i_clk  input  1  sole clock, all state changes on rising edge.
REQ-003 Port: i_rstn  input  1  reset, asynchronous, active-low.
REQ-004 Port: i_valid  input  1  request strobe; operands and mode valid while high.
REQ-005 Port: o_ready  output  1  block can accept a request this cycle.
REQ-006 Port: i_a  input  W  operand A, unsigned or two's complement.
REQ-007 Port: i_b  input  W  operand B.
REQ-008 Port: i_c  input  1  carry-in for add mode; ignored in subtract mode.
REQ-009 Port: i_sub  input  1  0 = A+B+i_c, 1 = A-B.
REQ-010 Port: o_valid  output  1  result valid; held until taken.
REQ-011 Port: i_ready  input  1  consumer accepts the result.
REQ-012 Port: o_s  output  W  sum or difference, modulo 2^W.
REQ-013 Port: o_c  output  1  final carry-out; in subtract mode 1 = no borrow (A >= B unsigned).
REQ-014 Port: o_ovf  output  1  signed overflow of the W-bit operation.

Function
REQ-015 The block shall contain exactly one 4-bit full-adder slice (4-bit sum plus carry, combinational) and reuse it once per nibble, LSB nibble first.
REQ-016 FSM states shall be IDLE, CALC, DONE.
REQ-017 o_ready shall be 1 only in IDLE; o_valid shall be 1 only in DONE.
REQ-018 IDLE->CALC on the cycle i_valid & o_ready is high: latch A, B (B inverted when i_sub=1), and carry register = (i_sub ? 1 : i_c); clear nibble counter to 0.
REQ-019 In CALC, each cycle shall add nibble[cnt] of latched A and B with the carry register, store the 4-bit sum into result nibble[cnt], update the carry register with the slice carry-out, and increment cnt.
REQ-020 CALC->DONE on the cycle processing nibble NIB-1; o_s, o_c, o_ovf shall be valid from the first DONE cycle.
REQ-021 Latency: o_valid shall rise exactly NIB+1 rising edges after the accepting edge's cycle, i.e., NIB CALC cycles then DONE.
REQ-022 o_ovf shall equal carry-into-MSB XOR carry-out-of-MSB of the final slice.
REQ-023 DONE->IDLE on the cycle o_valid & i_ready is high; o_s, o_c, o_ovf shall hold their values until the next request completes.
REQ-024 i_valid in CALC or DONE shall be ignored (no latch, no state change); the requester must hold i_valid until o_ready.
REQ-025 Operand inputs changing after acceptance shall not affect the in-flight result.
REQ-026 i_ready asserted outside DONE shall have no effect.
REQ-027 Throughput: at most one operation per NIB+2 cycles (accept, NIB CALC, DONE with i_ready=1).

Reset
REQ-028 When i_rstn=0, the FSM shall go to IDLE immediately, regardless of the clock.
REQ-029 Reset values: o_ready=1 (after reset deasserts), o_valid=0, o_s=0, o_c=0, o_ovf=0, counter=0, carry register=0.
REQ-030 Reset during CALC or DONE shall abort the operation with no result delivered; the first post-reset request shall behave identically to one issued after power-on.

Verification
REQ-031 NIB=4, add: A=16'h1234, B=16'h4321, i_c=0 -> o_valid 5 edges after accept; o_s=16'h5555, o_c=0, o_ovf=0.
REQ-032 Add wrap: A=16'hFFFF, B=16'h0001, i_c=0 -> o_s=16'h0000, o_c=1, o_ovf=0. Signed overflow: A=16'h7FFF, B=16'h0001 -> o_s=16'h8000, o_ovf=1.
REQ-033 Subtract: A=16'h0005, B=16'h0007, i_sub=1 -> o_s=16'hFFFE, o_c=0 (borrow), o_ovf=0. Subtract: A=16'h8000, B=16'h0001 -> o_s=16'h7FFF, o_c=1, o_ovf=1.
REQ-034 Backpressure: hold i_ready=0 for 10 cycles in DONE, then toggle i_a/i_valid -> o_valid and o_s stable throughout, no new accept; on i_ready=1, IDLE next cycle, o_ready=1.
REQ-035 Reset mid-CALC: assert i_rstn=0 after 2 CALC cycles, between clock edges -> o_valid=0 and outputs 0 immediately; a following request A=16'h0001, B=16'h0001 -> o_s=16'h0002 with normal latency.
REQ-036 Random self-check: 10k requests with random A, B, i_c, i_sub, i_valid and i_ready gaps, for NIB=1, 4 and 8 -> every result matches the W-bit reference model for o_s, o_c and o_ovf, with no dropped or duplicated results.
